// File: rtl/vga_pattern_tx.sv
// 800x600@60 VGA-style test-pattern source with 1-bit sigma-delta colour streams.
// Pipeline: counters -> pattern level register -> modulator/output register, 2 cycles end to end.
module vga_pattern_tx #(
    parameter int H_VIS  = 800,
    parameter int H_FP   = 40,
    parameter int H_SYNC = 128,
    parameter int H_BP   = 88,
    parameter int V_VIS  = 600,
    parameter int V_FP   = 1,
    parameter int V_SYNC = 4,
    parameter int V_BP   = 23,
    parameter int HS_POL = 1,
    parameter int VS_POL = 1,
    parameter int BAR_W  = 100,
    parameter int GRAD_W = 50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  pattern_sel,
    input  logic [11:0] solid_rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        red_bit,
    output logic        green_bit,
    output logic        blue_bit,
    output logic        visible,
    output logic        frame_start
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    // at least 6 bits so the checkerboard can always use bit 5 of either counter
    localparam int HW = ($clog2(H_TOT) > 6) ? $clog2(H_TOT) : 6;
    localparam int VW = ($clog2(V_TOT) > 6) ? $clog2(V_TOT) : 6;
    localparam int BW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int GW = (GRAD_W > 1) ? $clog2(GRAD_W) : 1;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VIS_C = HW'(H_VIS);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VIS_C = VW'(V_VIS);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [BW-1:0] BAR_LAST  = BW'(BAR_W - 1);
    localparam logic [GW-1:0] GRAD_LAST = GW'(GRAD_W - 1);
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic [BW-1:0] bar_cnt;
    logic [2:0]    bar_idx;
    logic [GW-1:0] grad_cnt;
    logic [3:0]    grad_step;
    logic [1:0]    pat_q;

    logic          at_origin, act0;
    logic [1:0]    pat_eff;
    logic [11:0]   lvl0;

    logic [11:0]   s1_lvl;
    logic          s1_act, s1_hs, s1_vs, s1_fs, s1_lstart;

    logic [3:0]    acc_r, acc_g, acc_b;
    logic [3:0]    base_r, base_g, base_b;
    logic [4:0]    sum_r, sum_g, sum_b;

    // Stage 0: position counters plus divider-free bar/gradient column counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            hcount    <= '0;
            vcount    <= '0;
            bar_cnt   <= '0;
            bar_idx   <= '0;
            grad_cnt  <= '0;
            grad_step <= '0;
            pat_q     <= '0;
        end else begin
            if (hcount == H_LAST) begin
                hcount    <= '0;
                bar_cnt   <= '0;
                bar_idx   <= '0;
                grad_cnt  <= '0;
                grad_step <= '0;
                vcount    <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
            end else begin
                hcount <= hcount + 1'b1;
                if (bar_cnt == BAR_LAST) begin
                    bar_cnt <= '0;
                    bar_idx <= bar_idx + 1'b1;
                end else begin
                    bar_cnt <= bar_cnt + 1'b1;
                end
                if (grad_cnt == GRAD_LAST) begin
                    grad_cnt <= '0;
                    if (grad_step != 4'hF) grad_step <= grad_step + 1'b1;
                end else begin
                    grad_cnt <= grad_cnt + 1'b1;
                end
            end
            if (at_origin) pat_q <= pattern_sel;
        end
    end

    // The origin pixel already uses the freshly latched selection, so a frame never mixes patterns.
    always_comb begin
        at_origin = (hcount == '0) && (vcount == '0);
        act0      = (hcount < H_VIS_C) && (vcount < V_VIS_C);
        pat_eff   = at_origin ? pattern_sel : pat_q;
        lvl0      = '0;
        if (act0) begin
            case (pat_eff)
                2'b00:   lvl0 = solid_rgb;
                2'b01:   lvl0 = {{4{bar_idx[2]}}, {4{bar_idx[1]}}, {4{bar_idx[0]}}};
                2'b10:   lvl0 = {3{grad_step}};
                default: lvl0 = {12{hcount[5] ^ vcount[5]}};
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_lvl    <= '0;
            s1_act    <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_fs     <= 1'b0;
            s1_lstart <= 1'b0;
        end else begin
            s1_lvl    <= lvl0;
            s1_act    <= act0;
            s1_hs     <= (hcount >= HS_BEG) && (hcount < HS_END);
            s1_vs     <= (vcount >= VS_BEG) && (vcount < VS_END);
            s1_fs     <= at_origin;
            s1_lstart <= (hcount == '0);
        end
    end

    // First-order sigma-delta: the carry out of acc+L is the output bit.
    always_comb begin
        base_r = s1_lstart ? 4'd0 : acc_r;
        base_g = s1_lstart ? 4'd0 : acc_g;
        base_b = s1_lstart ? 4'd0 : acc_b;
        sum_r  = {1'b0, base_r} + {1'b0, s1_lvl[11:8]};
        sum_g  = {1'b0, base_g} + {1'b0, s1_lvl[7:4]};
        sum_b  = {1'b0, base_b} + {1'b0, s1_lvl[3:0]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_r       <= '0;
            acc_g       <= '0;
            acc_b       <= '0;
            red_bit     <= 1'b0;
            green_bit   <= 1'b0;
            blue_bit    <= 1'b0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            visible     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (s1_act) begin
                acc_r     <= sum_r[3:0];
                acc_g     <= sum_g[3:0];
                acc_b     <= sum_b[3:0];
                red_bit   <= sum_r[4];
                green_bit <= sum_g[4];
                blue_bit  <= sum_b[4];
            end else begin
                acc_r     <= '0;
                acc_g     <= '0;
                acc_b     <= '0;
                red_bit   <= 1'b0;
                green_bit <= 1'b0;
                blue_bit  <= 1'b0;
            end
            hsync       <= s1_hs ? HS_ON : ~HS_ON;
            vsync       <= s1_vs ? VS_ON : ~VS_ON;
            visible     <= s1_act;
            frame_start <= s1_fs;
        end
    end
endmodule

// File: tb/tb_vga_pattern_tx.sv
// Directed bench for vga_pattern_tx; full horizontal timing, shortened vertical timing (14-line frame).
module tb_vga_pattern_tx;
    localparam int LINE  = 1056;
    localparam int FRAME = 14 * LINE;   // 6 visible + 1 fp + 4 sync + 3 bp lines

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  pattern_sel;
    logic [11:0] solid_rgb;
    logic        hsync, vsync, red_bit, green_bit, blue_bit, visible, frame_start;

    vga_pattern_tx #(.V_VIS(6), .V_FP(1), .V_SYNC(4), .V_BP(3)) dut (
        .clock(clock), .reset(reset), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
        .hsync(hsync), .vsync(vsync), .red_bit(red_bit), .green_bit(green_bit),
        .blue_bit(blue_bit), .visible(visible), .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vis_tot, vis_bad, vs_cnt, vs_first;
    bit r_a [LINE];
    bit g_a [LINE];
    bit b_a [LINE];
    bit hs_a[LINE];
    bit vi_a[LINE];
    bit fs_a[LINE];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cyc=%0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int outs();
        return {hsync, vsync, red_bit, green_bit, blue_bit, visible, frame_start};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (visible) vis_tot++;
        if (visible && cyc >= 6 * LINE + 2 && cyc < FRAME + 2) vis_bad++;
        if (vsync) begin
            vs_cnt++;
            if (vs_first < 0) vs_first = cyc;
        end
    endtask

    task automatic wait_fs(input int exp);
        int limit;
        limit = exp - cyc + 16;
        for (int n = 0; n < limit && !frame_start; n++) tick();
        chk("frame_start_cycle", cyc, exp);
    endtask

    // Entered with the output at h=0; leaves at h=0 of the next line.
    task automatic capture_line();
        for (int h = 0; h < LINE; h++) begin
            r_a[h] = red_bit;   g_a[h] = green_bit; b_a[h] = blue_bit;
            hs_a[h] = hsync;    vi_a[h] = visible;  fs_a[h] = frame_start;
            tick();
        end
    endtask

    function automatic int ones(input int ch, input int lo, input int hi);
        int n = 0;
        for (int h = lo; h <= hi; h++)
            case (ch)
                0: n += int'(r_a[h]);
                1: n += int'(g_a[h]);
                2: n += int'(b_a[h]);
                3: n += int'(hs_a[h]);
                4: n += int'(vi_a[h]);
                default: n += int'(fs_a[h]);
            endcase
        return n;
    endfunction

    function automatic int first_hs();
        for (int h = 0; h < LINE; h++) if (hs_a[h]) return h;
        return -1;
    endfunction

    initial begin
        reset = 1'b1; pattern_sel = 2'b00; solid_rgb = 12'hF80;
        repeat (3) tick();
        chk("reset_outputs", outs(), 0);

        reset = 1'b0; cyc = 0;
        vis_tot = 0; vis_bad = 0; vs_cnt = 0; vs_first = -1;
        tick();
        chk("pipeline_fill_c1", outs(), 0);
        wait_fs(2);
        chk("visible_at_c2", int'(visible), 1);

        // frame 1 line 0: solid F80
        capture_line();
        chk("hs_first_h", first_hs(), 840);
        chk("hs_width", ones(3, 0, LINE - 1), 128);
        chk("hs_in_window", ones(3, 840, 967), 128);
        chk("vis_per_line", ones(4, 0, 799), 800);
        chk("vis_in_blank", ones(4, 800, LINE - 1), 0);
        chk("fs_per_line", ones(5, 0, LINE - 1), 1);
        chk("red_first16", ones(0, 0, 15), 15);
        chk("red_line", ones(0, 0, 799), 750);
        chk("green_h0", int'(g_a[0]), 0);
        chk("green_h1", int'(g_a[1]), 1);
        chk("green_first16", ones(1, 0, 15), 8);
        chk("blue_line", ones(2, 0, 799), 0);
        chk("blank_bits", ones(0, 800, LINE - 1) + ones(1, 800, LINE - 1) + ones(2, 800, LINE - 1), 0);

        capture_line();
        chk("line_period_hs", first_hs(), 840);

        pattern_sel = 2'b01;
        capture_line();
        chk("solid_held_midframe", ones(0, 0, 799), 750);

        wait_fs(2 + FRAME);
        chk("vsync_first_cycle", vs_first, 7 * LINE + 2);
        chk("vsync_cycles", vs_cnt, 4 * LINE);
        // 6 lines x 800, plus pixel 0 of the next frame sampled at its frame_start
        chk("visible_frame_total", vis_tot, 4801);
        chk("visible_in_vblank", vis_bad, 0);

        // frame 2: bars
        capture_line();
        chk("bar0_black", ones(0, 0, 99) + ones(1, 0, 99) + ones(2, 0, 99), 0);
        chk("bar1_rg", ones(0, 100, 199) + ones(1, 100, 199), 0);
        chk("bar1_blue", ones(2, 100, 199), 93);
        chk("bar7_density", ones(0, 700, 715) + ones(1, 700, 715) + ones(2, 700, 715), 45);
        chk("bars_blank", ones(0, 800, LINE - 1) + ones(1, 800, LINE - 1) + ones(2, 800, LINE - 1), 0);

        pattern_sel = 2'b11;
        capture_line();
        chk("bars_held_bar0", ones(0, 0, 99) + ones(1, 0, 99), 0);
        chk("bars_held_bar1", ones(2, 100, 199), 93);

        // frame 3: checkerboard, line 0 so v[5]=0
        wait_fs(2 + 2 * FRAME);
        capture_line();
        chk("chk_dark_0_31", ones(0, 0, 31), 0);
        chk("chk_lit_32_47", ones(0, 32, 47), 15);
        chk("chk_red_line", ones(0, 0, 799), 360);
        chk("chk_blue_line", ones(2, 0, 799), 360);

        pattern_sel = 2'b10;
        wait_fs(2 + 3 * FRAME);
        capture_line();
        chk("grad_0_49", ones(0, 0, 49), 0);
        chk("grad_750_765", ones(0, 750, 765), 15);
        chk("grad_line0", ones(0, 0, 799), 375);
        capture_line();
        chk("grad_line1_restart", ones(1, 0, 799), 375);

        capture_line();
        repeat (900) tick();
        chk("hsync_before_reset", int'(hsync), 1);
        reset = 1'b1;
        tick();
        chk("reset_midframe", outs(), 0);
        reset = 1'b0; cyc = 0;
        wait_fs(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_pattern_tx.md
# vga_pattern_tx

- Generates a complete 800x600@60 VGA-style stream (40 MHz pixel clock): hsync, vsync and one 1-bit line per colour channel.
- Drives GPIO so the capture path's comparator inputs and sync inputs can be exercised with a known signal.
- Each colour intensity is a 4-bit level. It is encoded as a first-order sigma-delta bit stream, so the capture side's per-pixel up/down integrator recovers the level.
- Sits beside the PLL on the same 40 MHz `clock` and is the transmitting end of the board-to-board video link.

## Interface
Parameters:
- H_VIS, 800, visible pixels per line
- H_FP, 40, horizontal front porch
- H_SYNC, 128, hsync width
- H_BP, 88, horizontal back porch (line total 1056)
- V_VIS, 600, visible lines
- V_FP, 1, vertical front porch
- V_SYNC, 4, vsync width
- V_BP, 23, vertical back porch (frame total 628)
- HS_POL, 1, active level of hsync
- VS_POL, 1, active level of vsync
- BAR_W, 100, colour-bar width in pixels
- GRAD_W, 50, gradient step width in pixels

Ports:
- clock  in  1  pixel clock; one clock domain, everything on its rising edge
- reset  in  1  synchronous, active-high
- pattern_sel  in  2  00 solid, 01 colour bars, 10 gradient, 11 checkerboard
- solid_rgb  in  12  solid-colour levels {R[11:8], G[7:4], B[3:0]}
- hsync  out  1  horizontal sync, polarity set by HS_POL
- vsync  out  1  vertical sync, polarity set by VS_POL
- red_bit, green_bit, blue_bit  out  1 each  sigma-delta colour streams
- visible  out  1  high while the output position is in the active area
- frame_start  out  1  one-cycle pulse when the output position is (0,0)

## Operation
Counters:
- hcount runs 0..1055 and wraps to 0. On wrap, vcount increments; vcount runs 0..627 and wraps to 0.
- Position (h,v) is active when h<H_VIS and v<V_VIS.
- hsync is active for h in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC), i.e. 840..967 at default parameters.
- vsync is active for v in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC), i.e. 601..604 at default parameters.

Pattern selection:
- pattern_sel is latched only when the counter is at (0,0). A change mid-frame takes effect at the next frame and never tears.
- solid_rgb is sampled every cycle.

Pattern stage (4-bit level L per channel, active area only):
- Solid: L = solid_rgb fields.
- Bars: bar index b = h/BAR_W, 0..7, computed with a column counter, not a divider. R = b[2]?15:0, G = b[1]?15:0, B = b[0]?15:0. Bar 0 is black, bar 7 is white.
- Gradient: all channels L = min(h/GRAD_W, 15), computed with a step counter.
- Checker: all channels L = (h[5]^v[5]) ? 15 : 0.
- Outside the active area: L = 0.

Modulator, one per channel:
- 4-bit accumulator. sum = acc + L (5 bits), bit = sum[4], acc <= sum[3:0].
- Accumulator is cleared at h=0 of every line, so every line is deterministic.
- Outside the active area the accumulator is held at 0 and the output bit is 0.
- L=15 gives 15 ones per 16 pixels; L=0 gives a constant 0.

## Timing
- Pipeline: counter → pattern stage register → modulator/output register. All outputs at cycle k describe the counter position of cycle k-2.
- hsync, vsync, visible and frame_start are delayed through the same two stages, so all outputs are mutually aligned.
- While reset is high:
  - counters are (0,0)
  - pipeline and accumulators are 0
  - pattern latch is 00
  - hsync = ~HS_POL, vsync = ~VS_POL
  - colour bits, visible and frame_start are 0
- First cycle after reset: the counter is at (0,0). Output position (0,0), with frame_start=1, appears 2 cycles later.
- Until the pipeline fills, outputs keep their reset values.
- Reset asserted mid-frame: all state returns to the reset values on the next edge. No partial line completes.

## Test plan
- Reset, then release with defaults:
  - hsync is inactive until output cycle 842 and active for cycles 842..969 (128 cycles).
  - Line period is 1056 cycles; frame period is 663168 cycles.
  - frame_start is high at cycles 2 and 663170.
- vsync check: active for exactly 4 lines. Its first active cycle is output cycle 601*1056+2. visible is high for 800 consecutive cycles on each of lines 0..599 and never on lines 600..627.
- Solid, solid_rgb=12'hF80:
  - red_bit: 15 ones in every 16-pixel window from h=0.
  - green_bit: 0 then 1 alternating (8 ones per 16), first bit 0.
  - blue_bit: always 0.
- Bars:
  - Pixels 0..99: all bits 0.
  - Pixels 100..199: blue only.
  - Pixels 700..799: all three channels at 15/16 density.
  - Pixels 800..1055 (blanking): all bits 0.
- Gradient: the ones count over pixels 750..765 is 15. The level of pixels 0..49 is 0. The accumulator restarts at each line start.
- pattern_sel changed from 01 to 11 mid-frame: the current frame stays bars. Checker starts exactly at the next frame_start. Asserting reset at vcount=300 gives reset values one cycle later.
